trivium: RTL and testbench
==========================

// Module: trivium
// PURPOSE
// - Trivium stream-cipher keystream generator (eSTREAM, 80-bit key, 80-bit IV, 288-bit NLFSR state).
// - Emits one keystream bit per clock on s.
// - Sits between the key/IV configuration registers and the data-path XOR that encrypts or decrypts the bitstream.
// - Re-keying is done by asserting reset with a new key/IV.
// PARAMETERS
// - WARMUP_CYCLES  1152  init rounds (4*288) before keystream is valid; used only when TRIVIUM_WARMUP_GATE_EN is defined
// - CNT_W          11    width of warm-up counter; must satisfy 2**CNT_W > WARMUP_CYCLES
// PORTS (positional order: s, iv, key, rst, clk)
// - clk  input   1   rising-edge clock, single domain
// - rst  input   1   reset, synchronous, active-low; when low at posedge, state is (re)loaded
// - s    output  1   keystream bit, registered
// - iv   input   80  initialisation vector IV[80:1]; sampled only while rst=0
// - key  input   80  secret key K[80:1]; sampled only while rst=0
// BEHAVIOUR
// - State S[1:288], registered. One round per clock whenever rst=1.
// - Load, at posedge with rst=0:
//   - S[1:80]=key[80:1] (S[i]=key[i]); S[81:93]=0
//   - S[94:173]=iv[80:1] (S[93+i]=iv[i]); S[174:177]=0
//   - S[178:285]=0; S[286:288]=3'b111
//   - s<=0, warm-up counter<=0
//   - key/iv changes while rst=1 have no effect.
// - Round, at posedge with rst=1, all terms taken from the current state:
//   - t1=S66^S93, t2=S162^S177, t3=S243^S288, z=t1^t2^t3
//   - n1=t1^(S91&S92)^S171; n2=t2^(S175&S176)^S264; n3=t3^(S286&S287)^S69
//   - S[1:93]<={n3,S[1:92]}; S[94:177]<={n1,S[94:176]}; S[178:288]<={n2,S[178:287]}
//   - s<=z (subject to gating below)
// - Latency: z of the loaded state appears on s one clock after the first posedge with rst=1.
// - Reset mid-operation: the next posedge with rst=0 discards all state, reloads, and drives s=0. No partial rounds.
// - Counter saturates at WARMUP_CYCLES and never wraps; it restarts only on reset.
// - Free-running: no stall input; keystream period is effectively unbounded.
// CONFIGURATION
// - Macro TRIVIUM_WARMUP_GATE_EN:
//   - defined: s is forced to 0 until the counter reaches WARMUP_CYCLES, i.e. for the 1152 rounds after reset release. The first emitted bit is z of round 1153, the standard keystream bit 1.
//   - undefined: no counter logic; s=z from the first round. The first 1152 bits are init-phase bits, for bring-up and debug only.
// TESTING
// - Macro undefined, key=0, iv=0, rst low 1 clk then high -> first four s bits 1,1,1,0.
// - Macro defined, same stimulus -> s=0 for 1152 clocks after release; bit 1153 onward matches the software reference model.
// - Standard key/IV vectors, macro defined -> first 512 s bits match the bit-accurate C model of the eSTREAM Trivium spec.
// - Reset mid-stream: run 300 clks, pull rst low 1 clk, release -> s=0 during reset; stream restarts identically to the first run.
// - Change key/iv while rst=1 -> stream unaffected. Then reset with new key -> stream matches the model for the new key.
// - Hold rst low 10 clks -> s stays 0; state equals the load pattern, with S[286:288]=3'b111.

Source files
------------

// File: rtl/trivium.sv
// Trivium keystream generator: one bit per clock on s, registered (z of loaded state one clock after reset release); free-running, no stall.
// Optional warm-up gating of s behind macro TRIVIUM_WARMUP_GATE_EN.
module trivium #(
  parameter int WARMUP_CYCLES = 1152,
  parameter int CNT_W         = 11
) (
  output logic        s,
  input  logic [79:0] iv,
  input  logic [79:0] key,
  input  logic        rst,
  input  logic        clk
);

  // State bit S[i] lives at state_q[i] so the cipher taps read as written in the algorithm.
  logic [288:1] state_q, state_d;
  logic [288:1] load_state;
  logic         s_q, s_d;
  logic         t1, t2, t3, z;
  logic         n1, n2, n3;

  assign load_state = {3'b111, 108'b0, 4'b0, iv, 13'b0, key};
  assign s          = s_q;

  always_comb begin
    t1 = state_q[66]  ^ state_q[93];
    t2 = state_q[162] ^ state_q[177];
    t3 = state_q[243] ^ state_q[288];
    z  = t1 ^ t2 ^ t3;
    n1 = t1 ^ (state_q[91]  & state_q[92])  ^ state_q[171];
    n2 = t2 ^ (state_q[175] & state_q[176]) ^ state_q[264];
    n3 = t3 ^ (state_q[286] & state_q[287]) ^ state_q[69];
    state_d = {state_q[287:178], n2, state_q[176:94], n1, state_q[92:1], n3};
  end

  // Elaborates only when the counter cannot hold WARMUP_CYCLES; widen CNT_W if this ever matches.
  if (WARMUP_CYCLES >= (1 << CNT_W)) begin : g_cnt_w_too_small
  end

`ifdef TRIVIUM_WARMUP_GATE_EN
  localparam logic [CNT_W-1:0] WARMUP_MAX = CNT_W'(WARMUP_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             warm;

  always_comb begin
    warm  = (cnt_q == WARMUP_MAX);
    cnt_d = warm ? cnt_q : cnt_q + 1'b1;
    s_d   = warm ? z : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= load_state;
      s_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  always_comb begin
    s_d = z;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= load_state;
      s_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
    end
  end
`endif

endmodule

// File: tb/tb_trivium.sv
// Self-checking bench for trivium: random key/IV streams against a bit-array Trivium model.
module tb_trivium;

`ifdef TRIVIUM_WARMUP_GATE_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif
  localparam int WARM = 1152;

  logic        clk;
  logic        rst;
  logic        s;
  logic [79:0] iv;
  logic [79:0] key;

  int checks;
  int errors;

  // Reference model state: m[i] is Trivium state bit S_i.
  bit m [1:288];
  int rounds;

  trivium dut (
    .s   (s),
    .iv  (iv),
    .key (key),
    .rst (rst),
    .clk (clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1, "watchdog");
  end

  task automatic model_load(input logic [79:0] k, input logic [79:0] v);
    for (int i = 1; i <= 288; i++) m[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      m[i]      = k[i-1];
      m[93 + i] = v[i-1];
    end
    m[286] = 1'b1;
    m[287] = 1'b1;
    m[288] = 1'b1;
    rounds = 0;
  endtask

  // Advance one round; e is the value s must show after it.
  task automatic model_next(output bit e);
    bit a1, a2, a3, zz, b1, b2, b3;
    a1 = m[66] ^ m[93];
    a2 = m[162] ^ m[177];
    a3 = m[243] ^ m[288];
    zz = a1 ^ a2 ^ a3;
    b1 = a1 ^ (m[91] & m[92]) ^ m[171];
    b2 = a2 ^ (m[175] & m[176]) ^ m[264];
    b3 = a3 ^ (m[286] & m[287]) ^ m[69];
    for (int i = 288; i > 178; i--) m[i] = m[i-1];
    for (int i = 177; i > 94; i--)  m[i] = m[i-1];
    for (int i = 93; i > 1; i--)    m[i] = m[i-1];
    m[1]   = b3;
    m[94]  = b1;
    m[178] = b2;
    rounds++;
    e = (GATED && rounds <= WARM) ? 1'b0 : zz;
  endtask

  function automatic logic [79:0] rand80();
    return {$urandom_range(65535, 0), $urandom(), $urandom()};
  endfunction

  // Hold reset for ncyc clocks with the given key/IV, checking s stays 0, then release.
  task automatic apply_reset(input logic [79:0] k, input logic [79:0] v, input int ncyc, input string name);
    key = k;
    iv  = v;
    rst = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      checks++;
      if (s !== 1'b0) begin
        errors++;
        $display("FAIL %s_s_in_reset cycle %0d: got %b, required 0", name, c, s);
      end
    end
    model_load(k, v);
    rst = 1'b1;
  endtask

  // Run n rounds comparing s with the model; emitted bits are appended to q.
  task automatic run_stream(input int n, input string name, inout bit q[$]);
    bit e;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      model_next(e);
      q.push_back(s);
      checks++;
      if (s !== e) begin
        errors++;
        $display("FAIL %s round %0d: got %b, required %b", name, rounds, s, e);
      end
    end
  endtask

  task automatic test_reset();
    logic [288:1] exp_state;
    bit q[$];
    apply_reset(rand80(), rand80(), 10, "reset_hold");
    for (int i = 1; i <= 288; i++) exp_state[i] = m[i];
    checks++;
    if (dut.state_q !== exp_state) begin
      errors++;
      $display("FAIL reset_load_state: got %h, required %h", dut.state_q, exp_state);
    end
    checks++;
    if (dut.state_q[288:286] !== 3'b111) begin
      errors++;
      $display("FAIL reset_load_tail: got %b, required 111", dut.state_q[288:286]);
    end
    run_stream(64, "reset_first_stream", q);
  endtask

  task automatic test_zero_vector();
    bit q[$];
    bit exp4 [4];
    exp4 = '{1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset('0, '0, 1, "zero");
    run_stream(GATED ? WARM + 64 : 64, "zero_stream", q);
    if (!GATED) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q[i] !== exp4[i]) begin
          errors++;
          $display("FAIL zero_first_bits bit %0d: got %b, required %b", i + 1, q[i], exp4[i]);
        end
      end
    end
  endtask

  task automatic test_random_stream();
    bit q[$];
    for (int r = 0; r < 2; r++) begin
      apply_reset(rand80(), rand80(), 1 + r, "rand");
      run_stream((GATED ? WARM : 0) + 512, "rand_stream", q);
    end
  endtask

  task automatic test_midstream_reset();
    bit q1[$];
    bit q2[$];
    logic [79:0] k, v;
    k = rand80();
    v = rand80();
    apply_reset(k, v, 1, "mid_first");
    run_stream(300, "mid_run1", q1);
    apply_reset(k, v, 1, "mid_again");
    run_stream(300, "mid_run2", q2);
    for (int i = 0; i < 300; i += 37) begin
      checks++;
      if (q2[i] !== q1[i]) begin
        errors++;
        $display("FAIL mid_restart_repeat bit %0d: got %b, required %b", i, q2[i], q1[i]);
      end
    end
  endtask

  task automatic test_key_change_running();
    bit q[$];
    apply_reset(rand80(), rand80(), 2, "kc");
    run_stream(50, "kc_before", q);
    key = rand80();
    iv  = rand80();
    run_stream(150, "kc_ignored", q);
    apply_reset(rand80(), rand80(), 1, "kc_rekey");
    run_stream((GATED ? WARM : 0) + 200, "kc_new_key", q);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    key    = '0;
    iv     = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_zero_vector();
    test_random_stream();
    test_midstream_reset();
    test_key_change_running();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
